// File: rtl/residual_error_generator.sv
// rtl/residual_error_generator.sv - channel convolution and residual subtraction ahead of the Viterbi core; optional macro RSE_GEN_SATURATE_EN
module residual_error_generator #(
  parameter int B_WIDTH           = 8,
  parameter int B_LEN             = 2,
  parameter int est_channel_width = 8,
  parameter int est_chan_depth    = 30,
  parameter int est_channel_shift = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [est_chan_depth-1:0][est_channel_width-1:0]  est_channel,
  input  logic                                              update,
  input  logic                                              flush,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [B_LEN-1:0][1:0]                             symbols_in,
  input  logic [B_LEN-1:0][B_WIDTH-1:0]                     codes_in,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [B_LEN-1:0][B_WIDTH-1:0]                     rse_vals,
  output logic                                              sym_err
);

  // Accumulator is wide enough for depth full-scale taps; difference gets one more bit.
  localparam int AW = est_channel_width + $clog2(est_chan_depth) + 1;
  localparam int DW = ((B_WIDTH > AW) ? B_WIDTH : AW) + 1;
  localparam int HD = est_chan_depth - 1;

  logic [est_chan_depth-1:0][est_channel_width-1:0] taps_q, taps_d;
  logic [HD-1:0][1:0]                               hist_q, hist_d;
  logic                                             s1_valid_q, s1_valid_d;
  logic [B_LEN-1:0][AW-1:0]                         s1_est_q, s1_est_d;
  logic [B_LEN-1:0][B_WIDTH-1:0]                    s1_codes_q, s1_codes_d;
  logic                                             s2_valid_q, s2_valid_d;
  logic [B_LEN-1:0][B_WIDTH-1:0]                    rse_q, rse_d;
  logic                                             sym_err_q, sym_err_d;

  logic                                             s1_adv, s2_adv, accept;
  logic [B_LEN-1:0][1:0]                            sym_clean;
  logic                                             beat_bad;
  logic [B_LEN-1:0][AW-1:0]                         est_shift;
  logic [B_LEN-1:0][B_WIDTH-1:0]                    rse_calc;

  // Handshake: stage 2 frees when empty or drained, stage 1 frees when stage 2 can take it.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    s1_adv   = !s1_valid_q || s2_adv;
    in_ready = s1_adv && !flush;
    accept   = in_valid && in_ready;
  end

  // The unused code 2'b10 is mapped to a zero symbol and flagged.
  always_comb begin
    sym_clean = symbols_in;
    beat_bad  = 1'b0;
    for (int k = 0; k < B_LEN; k++) begin
      if (symbols_in[k] == 2'b10) begin
        sym_clean[k] = 2'b00;
        beat_bad     = 1'b1;
      end
    end
  end

  // Per-lane convolution: lanes below k are older samples of this beat, then history (index 0 newest).
  always_comb begin
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] tap;
    logic [1:0]           s;
    est_shift = '0;
    acc       = '0;
    tap       = '0;
    s         = 2'b00;
    for (int k = 0; k < B_LEN; k++) begin
      acc = '0;
      for (int i = 0; i < est_chan_depth; i++) begin
        if (i <= k) begin
          s = sym_clean[k-i];
        end else begin
          s = hist_q[i-k-1];
        end
        tap = AW'($signed(taps_q[i]));
        case (s)
          2'b01:   acc = acc + tap;
          2'b11:   acc = acc - tap;
          default: acc = acc;
        endcase
      end
      est_shift[k] = acc >>> est_channel_shift;
    end
  end

  // Residual at full width, then narrowed by wrap or clamp depending on build.
  always_comb begin
    logic signed [DW-1:0] diff;
    rse_calc = '0;
    diff     = '0;
    for (int k = 0; k < B_LEN; k++) begin
      diff = DW'($signed(s1_codes_q[k])) - DW'($signed(s1_est_q[k]));
`ifdef RSE_GEN_SATURATE_EN
      if (diff[DW-1:B_WIDTH-1] != {(DW-B_WIDTH+1){diff[DW-1]}}) begin
        rse_calc[k] = diff[DW-1] ? {1'b1, {(B_WIDTH-1){1'b0}}} : {1'b0, {(B_WIDTH-1){1'b1}}};
      end else begin
        rse_calc[k] = diff[B_WIDTH-1:0];
      end
`else
      rse_calc[k] = diff[B_WIDTH-1:0];
`endif
    end
  end

  // Next state: tap latch, history shift on accept, two-stage pipeline, sticky error.
  always_comb begin
    taps_d     = taps_q;
    hist_d     = hist_q;
    s1_valid_d = s1_valid_q;
    s1_est_d   = s1_est_q;
    s1_codes_d = s1_codes_q;
    s2_valid_d = s2_valid_q;
    rse_d      = rse_q;
    sym_err_d  = sym_err_q;

    if (update) begin
      taps_d = est_channel;
    end

    if (flush) begin
      hist_d     = '0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      sym_err_d  = 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          rse_d = rse_calc;
        end
      end
      if (s1_adv) begin
        s1_valid_d = accept;
      end
      if (accept) begin
        s1_est_d   = est_shift;
        s1_codes_d = codes_in;
        for (int j = 0; j < HD; j++) begin
          if (j < B_LEN) begin
            hist_d[j] = sym_clean[B_LEN-1-j];
          end else begin
            hist_d[j] = hist_q[j-B_LEN];
          end
        end
        if (beat_bad) begin
          sym_err_d = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q     <= '0;
      hist_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_est_q   <= '0;
      s1_codes_q <= '0;
      s2_valid_q <= 1'b0;
      rse_q      <= '0;
      sym_err_q  <= 1'b0;
    end else begin
      taps_q     <= taps_d;
      hist_q     <= hist_d;
      s1_valid_q <= s1_valid_d;
      s1_est_q   <= s1_est_d;
      s1_codes_q <= s1_codes_d;
      s2_valid_q <= s2_valid_d;
      rse_q      <= rse_d;
      sym_err_q  <= sym_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign rse_vals  = rse_q;
  assign sym_err   = sym_err_q;

endmodule

// File: tb/tb_residual_error_generator.sv
// tb/tb_residual_error_generator.sv - scoreboard bench for residual_error_generator
module tb_residual_error_generator;

  logic              clk;
  logic              rst_n;
  logic [29:0][7:0]  est_channel;
  logic              update;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0][1:0]   symbols_in;
  logic [1:0][7:0]   codes_in;
  logic              out_valid;
  logic              out_ready;
  logic [1:0][7:0]   rse_vals;
  logic              sym_err;

  int                vectors = 0;
  int                fails = 0;
  int                h_m[30];
  int                hist_m[$];
  logic [15:0]       exp_q[$];
  logic [15:0]       mon_e;

  residual_error_generator dut (
    .clk(clk), .rst_n(rst_n), .est_channel(est_channel), .update(update),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .symbols_in(symbols_in), .codes_in(codes_in), .out_valid(out_valid),
    .out_ready(out_ready), .rse_vals(rse_vals), .sym_err(sym_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int symval(input logic [1:0] s);
    if (s == 2'b01) return 1;
    if (s == 2'b11) return -1;
    return 0;
  endfunction

  // Reference: direct convolution over the whole accepted symbol sequence.
  function automatic logic [15:0] model_beat(input logic [1:0] a0, input logic [1:0] a1,
                                             input int c0, input int c1);
    int seq[$];
    int p, acc, est, diff, code;
    logic [31:0] dv;
    logic [15:0] r;
    seq = hist_m;
    seq.push_back(symval(a0));
    seq.push_back(symval(a1));
    r = '0;
    for (int k = 0; k < 2; k++) begin
      p = hist_m.size() + k;
      acc = 0;
      for (int i = 0; i < 30; i++) begin
        if (p - i >= 0) acc += h_m[i] * seq[p-i];
      end
      est = acc >>> 1;
      code = (k == 0) ? c0 : c1;
      diff = code - est;
`ifdef RSE_GEN_SATURATE_EN
      if (diff > 127) diff = 127;
      if (diff < -128) diff = -128;
`endif
      dv = diff;
      r[k*8 +: 8] = dv[7:0];
    end
    return r;
  endfunction

  // Output side of the scoreboard: every transfer pops one expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat got=%h want=none", rse_vals);
      end else begin
        mon_e = exp_q.pop_front();
        if (rse_vals !== mon_e) begin
          fails++;
          $display("FAIL beat got=%h want=%h", rse_vals, mon_e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic clear_taps();
    for (int i = 0; i < 30; i++) h_m[i] = 0;
  endtask

  task automatic load_taps();
    for (int i = 0; i < 30; i++) est_channel[i] = h_m[i][7:0];
    update = 1'b1;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  // Drive one beat (called just after a rising edge), push its expectation on accept.
  task automatic send(input logic [1:0] a0, input logic [1:0] a1, input int c0, input int c1);
    int n;
    n = 0;
    symbols_in = {a1, a0};
    codes_in   = {c1[7:0], c0[7:0]};
    in_valid   = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      vectors++;
      fails++;
      $display("FAIL send_timeout got=in_ready_low want=accept");
    end else begin
      exp_q.push_back(model_beat(a0, a1, c0, c1));
      hist_m.push_back(symval(a0));
      hist_m.push_back(symval(a1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      fails++;
      $display("FAIL drain_timeout got=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; update = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    symbols_in = '0; codes_in = '0; est_channel = '0;
    clear_taps();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    vectors++; if (rse_vals !== 16'h0) begin fails++; $display("FAIL reset_rse got=%h want=0000", rse_vals); end
    vectors++; if (sym_err !== 1'b0) begin fails++; $display("FAIL reset_sym_err got=%b want=0", sym_err); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_taps(); h_m[0] = 16; h_m[1] = 8; load_taps();
    send(2'b01, 2'b01, 10, 12);
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early got=%b want=0", out_valid); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b1) begin fails++; $display("FAIL latency_due got=%b want=1", out_valid); end
    @(posedge clk); #1;
    send(2'b11, 2'b00, 0, 0);
    drain();
  endtask

  task automatic test_saturation();
    clear_taps(); h_m[0] = 127; load_taps();
    send(2'b11, 2'b00, 127, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [1:0] legal[3];
    legal[0] = 2'b00; legal[1] = 2'b01; legal[2] = 2'b11;
    for (int i = 0; i < 30; i++) h_m[i] = int'($urandom_range(0, 40)) - 20;
    load_taps();
    for (int b = 0; b < 16; b++) begin
      send(legal[$urandom_range(0, 2)], legal[$urandom_range(0, 2)],
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [1:0] bs0[6];
    logic [1:0] bs1[6];
    int bc0[6];
    int bc1[6];
    int idx, acc;
    clear_taps(); h_m[0] = 16; h_m[1] = 8; h_m[2] = -4; load_taps();
    for (int i = 0; i < 6; i++) begin
      bs0[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
      bs1[i] = (i % 3 == 0) ? 2'b11 : 2'b01;
      bc0[i] = 10 * i - 20;
      bc1[i] = 7 - 5 * i;
    end
    out_ready = 1'b0; idx = 0; acc = 0;
    symbols_in = {bs1[0], bs0[0]}; codes_in = {bc1[0][7:0], bc0[0][7:0]}; in_valid = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (in_ready && idx < 5) begin
        exp_q.push_back(model_beat(bs0[idx], bs1[idx], bc0[idx], bc1[idx]));
        hist_m.push_back(symval(bs0[idx]));
        hist_m.push_back(symval(bs1[idx]));
        acc++;
        idx++;
      end
      @(posedge clk); #1;
      symbols_in = {bs1[idx], bs0[idx]}; codes_in = {bc1[idx][7:0], bc0[idx][7:0]};
    end
    vectors++; if (acc !== 2) begin fails++; $display("FAIL bp_accepts got=%0d want=2", acc); end
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    send(bs0[5], bs1[5], bc0[5], bc1[5]);
    drain();
  endtask

  task automatic test_illegal_and_flush();
    clear_taps(); h_m[0] = 16; h_m[1] = 8; load_taps();
    vectors++; if (sym_err !== 1'b0) begin fails++; $display("FAIL err_before got=%b want=0", sym_err); end
    send(2'b01, 2'b10, 30, -30);
    @(negedge clk);
    vectors++; if (sym_err !== 1'b1) begin fails++; $display("FAIL err_set got=%b want=1", sym_err); end
    @(posedge clk); #1;
    drain();
    out_ready = 1'b0;
    send(2'b00, 2'b01, 1, 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.delete();
    hist_m.delete();
    @(negedge clk);
    vectors++; if (sym_err !== 1'b0) begin fails++; $display("FAIL flush_sym_err got=%b want=0", sym_err); end
    vectors++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(2'b00, 2'b00, 0, 0);
    drain();
  endtask

  task automatic test_update_coincide();
    clear_taps(); h_m[0] = 16; h_m[1] = 8; load_taps();
    est_channel[0] = 8'd32;
    update = 1'b1;
    send(2'b01, 2'b01, 20, 20);
    update = 1'b0;
    h_m[0] = 32;
    send(2'b01, 2'b00, 20, 20);
    drain();
  endtask

  task automatic test_async_reset();
    clear_taps(); h_m[0] = 16; h_m[1] = 8; load_taps();
    out_ready = 1'b0;
    send(2'b01, 2'b10, 5, 6);
    send(2'b00, 2'b01, 7, 8);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_out_valid got=%b want=0", out_valid); end
    vectors++; if (rse_vals !== 16'h0) begin fails++; $display("FAIL areset_rse got=%h want=0000", rse_vals); end
    vectors++; if (sym_err !== 1'b0) begin fails++; $display("FAIL areset_sym_err got=%b want=0", sym_err); end
    vectors++; if (in_ready !== 1'b1) begin fails++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
    exp_q.delete();
    hist_m.delete();
    clear_taps();
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b01, 2'b01, 5, -3);
    h_m[3] = 8;
    load_taps();
    send(2'b00, 2'b00, 0, 0);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_illegal_and_flush();
    test_update_coincide();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/residual_error_generator.md
# residual_error_generator

Encoder-side counterpart of the Viterbi detector: convolves a stream of decided or training symbols with the estimated channel and subtracts the result from the received codes, producing the `rse_vals` residual-error lanes the detector consumes. Sits between the FFE/slicer output and the Viterbi core. It keeps its own symbol history and a latched channel copy, and moves beats through a 2-stage valid/ready pipeline.

## Interface
- `B_WIDTH`, 8: signed width of codes and residuals.
- `B_LEN`, 2: symbols/codes per beat (lanes).
- `est_channel_width`, 8: signed width of each channel tap.
- `est_chan_depth`, 30: number of channel taps.
- `est_channel_shift`, 1: arithmetic right shift applied to each convolution sum.

- `clk`, input, 1: clock; all state on rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `est_channel`, input, `[est_channel_width-1:0] x est_chan_depth`, signed: channel taps; tap 0 is the cursor.
- `update`, input, 1: latch `est_channel` into the internal tap register.
- `flush`, input, 1: synchronous clear of history, pipeline and error flag.
- `in_valid`, input, 1: the input beat is valid.
- `in_ready`, output, 1: the block accepts a beat this cycle.
- `symbols_in`, input, `[1:0] x B_LEN`, signed: lane 0 is oldest in time.
- `codes_in`, input, `[B_WIDTH-1:0] x B_LEN`, signed: received codes aligned with `symbols_in`.
- `out_valid`, output, 1: `rse_vals` is valid.
- `out_ready`, input, 1: the downstream consumer takes a beat.
- `rse_vals`, output, `[B_WIDTH-1:0] x B_LEN`, signed: residuals.
- `sym_err`, output, 1: sticky flag for an illegal symbol.

## Operation
- Legal symbols are -1, 0, +1. The value 2'b10 (-2) is treated as 0 and sets `sym_err`. `sym_err` clears only on reset or `flush`.
- Tap register: loads `est_channel` at every edge where `update`=1. Reset value: all taps 0.
- History holds the last `est_chan_depth-1` accepted symbols. Reset value: all 0.
- On accept (`in_valid && in_ready`), the B_LEN new symbols shift in with lane B_LEN-1 becoming the newest.
- Lane k convolution: `est[k] = sum_{i=0}^{depth-1} h[i]*s(t_k - i)`, where `s(t_k)` = `symbols_in[k]`. Older samples come from lower lanes of the same beat, then from history.
- Products are ±h[i] or 0. The accumulator width is `est_channel_width + $clog2(est_chan_depth) + 1`, so it never overflows.
- Stage 1 registers each lane's `est[k] >>> est_channel_shift` (arithmetic shift, floor rounding) together with `codes_in`.
- Stage 2 registers `rse_vals[k] = codes_in[k] - est_shifted[k]`, computed at full width and then narrowed to B_WIDTH (see Configuration).
- Pipeline advance:
  - `s2_adv = !s2_valid || out_ready`.
  - `s1_adv = !s1_valid || s2_adv`.
  - `in_ready = s1_adv && !flush`.
  - `in_ready` depends combinationally on `out_ready`; no skid buffer.
- `out_valid` = `s2_valid`. `rse_vals` holds steady while `out_valid && !out_ready`.
- `flush`: on the next edge, history is zeroed, `s1_valid` and `s2_valid` are cleared, and `sym_err` is cleared. In-flight beats are dropped. The tap register is unaffected.
- `update` together with an accept in the same cycle: the accepted beat uses the old taps. Beats already in stage 1 or 2 are never recomputed.
- `update` together with `flush`: both take effect.
- Reset mid-stream: all state returns to reset values immediately.

## Timing
- Reset values: `in_ready`=1 (once `rst_n` is high and `flush`=0), `out_valid`=0, `rse_vals`=0, `sym_err`=0.
- Latency: a beat accepted at edge N appears with `out_valid`=1 after edge N+1, with `out_ready` held high.
- Throughput: 1 beat per cycle while `out_ready`=1.
- Backpressure: with `out_ready`=0, at most 2 beats are buffered. `in_ready` drops in the cycle both stages are full.
- History updates only on accept. Stalled cycles do not shift it.

## Configuration
- `RSE_GEN_SATURATE_EN`:
  - Defined: residuals saturate to [-2^(B_WIDTH-1), 2^(B_WIDTH-1)-1].
  - Undefined: residuals are truncated to the low B_WIDTH bits (two's-complement wrap).
  - Everything else is identical in both builds.

## Test plan
- Basic convolution:
  - Setup: reset, then `update` with h[0]=16, h[1]=8, others 0.
  - Stimulus: accept symbols {+1,+1}, codes {10,12}.
  - Required: 2 cycles later `rse_vals`={2,0}.
  - Stimulus: next beat symbols {-1,0}, codes {0,0}.
  - Required: est = {(-16+8)>>>1, (0-8)>>>1} = {-4,-4}, so `rse_vals`={4,4}.
- Saturation:
  - Setup: h[0]=127, symbol -1, code 127.
  - Required: est = -64, so `rse_vals` = 127 with the macro and -65 without.
- Backpressure:
  - Stimulus: hold `out_ready`=0 and drive `in_valid`=1 continuously.
  - Required: exactly 2 beats accepted, then `in_ready`=0.
  - Stimulus: release `out_ready`.
  - Required: beats emerge in order with no loss or duplication; history advances exactly once per accepted beat.
- Illegal symbol:
  - Stimulus: a symbol of 2'b10 in lane 1.
  - Required: `sym_err`=1 from the next cycle; the residual matches symbol 0.
  - Stimulus: `flush`.
  - Required: `sym_err`=0, `out_valid`=0, and the next beat sees zero history.
- Update coincidence:
  - Stimulus: change h[0] 16→32 with `update` in the same cycle as an accept.
  - Required: that beat uses 16; the following beat uses 32.
- Async reset mid-stream:
  - Stimulus: assert `rst_n`=0 with both stages full.
  - Required: `out_valid`=0, `rse_vals`=0, taps and history zero immediately, without waiting for a clock edge.
